// File: rtl/microev_bp_pkg.sv
// Shared opcodes, FSM state encoding and 2-bit counter helpers for the
// MicroEV20 conditional-branch predictor.
package microev_bp_pkg;

  localparam logic [2:0] OP_JMP = 3'b100;
  localparam logic [2:0] OP_JZE = 3'b101;
  localparam logic [2:0] OP_JNE = 3'b110;
  localparam logic [2:0] OP_JCY = 3'b111;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    FLUSH   = 2'd2
  } bp_state_e;

  localparam logic [1:0] CTR_RESET = 2'b01;
  localparam logic [1:0] CTR_MAX   = 2'b11;

  // Saturating step of a 2-bit direction counter.
  function automatic logic [1:0] ctr_step(input logic [1:0] ctr, input logic taken);
    logic [1:0] res;
    res = ctr;
    if (taken) begin
      if (ctr != CTR_MAX) res = ctr + 2'd1;
    end else begin
      if (ctr != 2'b00) res = ctr - 2'd1;
    end
    return res;
  endfunction

endpackage

// File: rtl/bp_counter_table.sv
// Table of 2-bit saturating direction counters: combinational read port,
// single synchronous update port. A same-cycle read of the written entry sees the old value.
module bp_counter_table
  import microev_bp_pkg::*;
#(
  parameter int IDX_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [1:0]       rd_ctr,
  input  logic             upd_en,
  input  logic [IDX_W-1:0] upd_idx,
  input  logic             upd_taken
);

  localparam int DEPTH = 1 << IDX_W;

  logic [1:0] ctr_reg [DEPTH];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) ctr_reg[i] <= CTR_RESET;
    end else if (upd_en) begin
      ctr_reg[upd_idx] <= ctr_step(ctr_reg[upd_idx], upd_taken);
    end
  end

  assign rd_ctr = ctr_reg[rd_idx];

endmodule

// File: rtl/branch_predict_sequencer.sv
// Conditional-jump sequencer: predicts JZE/JNE/JCY from a PC-indexed counter
// table, holds the branch until flags resolve, and drives flush/redirect on mispredict.
module branch_predict_sequencer
  import microev_bp_pkg::*;
#(
  parameter int PC_W         = 11,
  parameter int INSTR_W      = 22,
  parameter int IDX_W        = 4,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               issue_valid,
  input  logic [INSTR_W-1:0] instr,
  input  logic [PC_W-1:0]    pc,
  output logic               issue_ready,
  output logic               pred_valid,
  output logic               pred_taken,
  output logic [PC_W-1:0]    pred_next,
  input  logic               resolve_valid,
  input  logic               flag_z,
  input  logic               flag_c,
  output logic               flush,
  output logic               redirect_valid,
  output logic [PC_W-1:0]    redirect_pc,
  output logic [7:0]         mispredict_cnt
);

  localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  bp_state_e        state_reg;
  logic [2:0]       op_reg;
  logic [IDX_W-1:0] idx_reg;
  logic [PC_W-1:0]  target_reg;
  logic [PC_W-1:0]  fall_reg;
  logic             guess_reg;
  logic [FC_W-1:0]  flush_cnt_reg;

  logic [2:0]       op;
  logic             is_jump;
  logic             is_cond;
  logic [PC_W-1:0]  target;
  logic [PC_W-1:0]  fall;
  logic [1:0]       rd_ctr;
  logic             actual;
  logic             upd_en;

  assign op      = instr[INSTR_W-1 -: 3];
  assign is_jump = instr[INSTR_W-1];
  assign is_cond = is_jump && (op != OP_JMP);
  assign target  = instr[PC_W-1:0];
  assign fall    = pc + PC_W'(1);

  always_comb begin
    actual = flag_c;
    case (op_reg)
      OP_JZE:  actual = flag_z;
      OP_JNE:  actual = !flag_z;
      default: actual = flag_c;
    endcase
  end

  assign upd_en      = (state_reg == PENDING) && resolve_valid;
  assign issue_ready = (state_reg == IDLE);

  bp_counter_table #(.IDX_W(IDX_W)) u_table (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_idx    (pc[IDX_W-1:0]),
    .rd_ctr    (rd_ctr),
    .upd_en    (upd_en),
    .upd_idx   (idx_reg),
    .upd_taken (actual)
  );

  // Middle instruction bits and the counter's low bit do not affect sequencing.
  logic unused_bits;
  assign unused_bits = ^{instr[INSTR_W-4:PC_W], rd_ctr[0]};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      op_reg         <= '0;
      idx_reg        <= '0;
      target_reg     <= '0;
      fall_reg       <= '0;
      guess_reg      <= 1'b0;
      flush_cnt_reg  <= '0;
      pred_valid     <= 1'b0;
      pred_taken     <= 1'b0;
      pred_next      <= '0;
      flush          <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      mispredict_cnt <= '0;
    end else begin
      pred_valid     <= 1'b0;
      redirect_valid <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (issue_valid) begin
            pred_valid <= 1'b1;
            if (!is_jump) begin
              pred_taken <= 1'b0;
              pred_next  <= fall;
            end else if (!is_cond) begin
              pred_taken <= 1'b1;
              pred_next  <= target;
            end else begin
              pred_taken <= rd_ctr[1];
              pred_next  <= rd_ctr[1] ? target : fall;
              op_reg     <= op;
              idx_reg    <= pc[IDX_W-1:0];
              target_reg <= target;
              fall_reg   <= fall;
              guess_reg  <= rd_ctr[1];
              state_reg  <= PENDING;
            end
          end
        end
        PENDING: begin
          if (resolve_valid) begin
            if (actual != guess_reg) begin
              state_reg      <= FLUSH;
              flush          <= 1'b1;
              redirect_valid <= 1'b1;
              redirect_pc    <= actual ? target_reg : fall_reg;
              flush_cnt_reg  <= FC_W'(FLUSH_CYCLES - 1);
              if (mispredict_cnt != 8'hFF) mispredict_cnt <= mispredict_cnt + 8'd1;
            end else begin
              state_reg <= IDLE;
            end
          end
        end
        FLUSH: begin
          // flush_cnt counts remaining window cycles after the current one.
          if (flush_cnt_reg == '0) begin
            flush     <= 1'b0;
            state_reg <= IDLE;
          end else begin
            flush_cnt_reg <= flush_cnt_reg - FC_W'(1);
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_branch_predict_sequencer.sv
// Scoreboard bench: the driver pushes expected predictions/redirects from a
// behavioural counter-table model; a negedge monitor pops and compares.
module tb_branch_predict_sequencer;

  localparam int PC_W = 11;
  localparam int INSTR_W = 22;
  localparam int FLUSH_CYCLES = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic issue_valid = 1'b0;
  logic [INSTR_W-1:0] instr = '0;
  logic [PC_W-1:0] pc = '0;
  logic issue_ready, pred_valid, pred_taken;
  logic [PC_W-1:0] pred_next;
  logic resolve_valid = 1'b0, flag_z = 1'b0, flag_c = 1'b0;
  logic flush, redirect_valid;
  logic [PC_W-1:0] redirect_pc;
  logic [7:0] mispredict_cnt;

  always #5 clk = ~clk;

  branch_predict_sequencer #(.PC_W(PC_W), .INSTR_W(INSTR_W), .IDX_W(4), .FLUSH_CYCLES(FLUSH_CYCLES)) dut (
    .clk(clk), .rst_n(rst_n), .issue_valid(issue_valid), .instr(instr), .pc(pc),
    .issue_ready(issue_ready), .pred_valid(pred_valid), .pred_taken(pred_taken),
    .pred_next(pred_next), .resolve_valid(resolve_valid), .flag_z(flag_z), .flag_c(flag_c),
    .flush(flush), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .mispredict_cnt(mispredict_cnt)
  );

  typedef struct { logic taken; logic [PC_W-1:0] nxt; } pred_t;
  typedef struct { logic [PC_W-1:0] tgt; int cnt; } redir_t;
  pred_t  pred_q[$];
  redir_t redir_q[$];

  int checks = 0;
  int errors = 0;

  // Reference model: counter values as plain integers 0..3, mispredict count as an int.
  int bht[16];
  int mis = 0;
  logic [2:0] p_op;
  int p_idx;
  logic [PC_W-1:0] p_tgt, p_fall;
  logic p_guess;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) bht[i] = 1;
    mis = 0;
  endtask

  // Monitor
  int run = 0;
  logic [PC_W-1:0] last_redir = '0;
  always @(negedge clk) begin
    if (pred_valid) begin
      if (pred_q.size() == 0) chk("pred_unexpected", 32'(pred_next), 32'hFFFF_FFFF);
      else begin
        pred_t e;
        e = pred_q.pop_front();
        chk("pred_taken", 32'(pred_taken), 32'(e.taken));
        chk("pred_next", 32'(pred_next), 32'(e.nxt));
      end
    end
    if (redirect_valid) begin
      if (redir_q.size() == 0) chk("redirect_unexpected", 32'(redirect_pc), 32'hFFFF_FFFF);
      else begin
        redir_t r;
        r = redir_q.pop_front();
        chk("redirect_pc", 32'(redirect_pc), 32'(r.tgt));
        chk("redirect_cnt", 32'(mispredict_cnt), 32'(r.cnt));
        chk("redirect_in_flush", 32'(flush), 32'd1);
        chk("redirect_first_cycle", run, 0);
        last_redir = r.tgt;
      end
    end
    if (!rst_n) run = 0;
    else if (flush) begin
      if (run > 0) chk("redirect_hold", 32'(redirect_pc), 32'(last_redir));
      run++;
    end else if (run > 0) begin
      chk("flush_len", run, FLUSH_CYCLES);
      run = 0;
    end
  end

  function automatic logic [INSTR_W-1:0] mk(input logic [2:0] op, input logic [PC_W-1:0] tgt);
    logic [7:0] mid;
    mid = 8'($urandom);
    if (!op[2]) return {1'b0, 21'($urandom)};
    return {op, mid, tgt};
  endfunction

  // Returns 1 if the instruction leaves a branch pending.
  task automatic issue(input logic [INSTR_W-1:0] ins, input logic [PC_W-1:0] p, output bit pend);
    logic [2:0] op;
    logic [PC_W-1:0] tgt, fall;
    pred_t e;
    op = ins[21:19];
    tgt = ins[10:0];
    fall = p + 11'd1;
    pend = 0;
    chk("issue_ready_idle", 32'(issue_ready), 32'd1);
    if (!ins[21]) begin e.taken = 0; e.nxt = fall; end
    else if (op == 3'b100) begin e.taken = 1; e.nxt = tgt; end
    else begin
      p_guess = (bht[p % 16] >= 2);
      e.taken = p_guess;
      e.nxt = p_guess ? tgt : fall;
      p_op = op; p_idx = p % 16; p_tgt = tgt; p_fall = fall;
      pend = 1;
    end
    pred_q.push_back(e);
    issue_valid = 1; instr = ins; pc = p;
    tick();
    issue_valid = 0; instr = 22'($urandom); pc = 11'($urandom);
  endtask

  // mode 0: random flags, 1: force mispredict, 2: force correct.
  task automatic resolve(input int hold, input int mode, input bit rst_in_flush);
    logic want, act;
    int n;
    for (int i = 0; i < hold; i++) begin
      issue_valid = 1'($urandom); instr = 22'($urandom); pc = 11'($urandom);
      chk("ready_pending", 32'(issue_ready), 32'd0);
      tick();
    end
    issue_valid = 0;
    flag_z = 1'($urandom); flag_c = 1'($urandom);
    if (mode != 0) begin
      want = (mode == 1) ? !p_guess : p_guess;
      if (p_op == 3'b101) flag_z = want;
      else if (p_op == 3'b110) flag_z = !want;
      else flag_c = want;
    end
    act = (p_op == 3'b101) ? flag_z : (p_op == 3'b110) ? !flag_z : flag_c;
    bht[p_idx] = act ? ((bht[p_idx] < 3) ? bht[p_idx] + 1 : 3) : ((bht[p_idx] > 0) ? bht[p_idx] - 1 : 0);
    if (act != p_guess) begin
      redir_t r;
      mis = (mis < 255) ? mis + 1 : 255;
      r.tgt = act ? p_tgt : p_fall;
      r.cnt = mis;
      redir_q.push_back(r);
    end
    resolve_valid = 1;
    tick();
    resolve_valid = 0;
    chk("mispredict_cnt", 32'(mispredict_cnt), 32'(mis));
    if (rst_in_flush) begin
      rst_n = 0;
      tick();
      rst_n = 1;
      model_reset();
      chk("rst_flush", 32'(flush), 0);
      chk("rst_ready", 32'(issue_ready), 1);
      chk("rst_cnt", 32'(mispredict_cnt), 0);
      chk("rst_redirect", 32'(redirect_valid), 0);
      return;
    end
    n = 0;
    while (!issue_ready && n < 50) begin
      resolve_valid = 1'($urandom); flag_z = 1'($urandom); flag_c = 1'($urandom);
      n++;
      tick();
    end
    resolve_valid = 0;
    chk("recover_cycles", n, (act != p_guess) ? FLUSH_CYCLES : 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    bit pend;
    logic [2:0] op;
    logic [PC_W-1:0] p;
    model_reset();
    repeat (3) tick();
    rst_n = 1;
    chk("reset_ready", 32'(issue_ready), 1);
    chk("reset_pred_valid", 32'(pred_valid), 0);
    chk("reset_pred_next", 32'(pred_next), 0);
    chk("reset_flush", 32'(flush), 0);
    chk("reset_redirect_pc", 32'(redirect_pc), 0);
    chk("reset_cnt", 32'(mispredict_cnt), 0);

    issue(22'h080123, 11'h010, pend);
    issue({3'b100, 8'h00, 11'h2A5}, 11'h7FF, pend);
    issue(22'h012345, 11'h7FF, pend);
    // Cold JZE mispredicts, then trains to strongly taken and saturates.
    issue({3'b101, 8'h00, 11'h100}, 11'h020, pend); resolve(0, 1, 0);
    for (int k = 0; k < 3; k++) begin
      issue({3'b101, 8'h00, 11'h100}, 11'h020, pend); resolve(0, 2, 0);
    end
    issue({3'b101, 8'h00, 11'h100}, 11'h020, pend); resolve(0, 1, 0);
    issue({3'b101, 8'h00, 11'h100}, 11'h020, pend); resolve(0, 2, 0);
    issue({3'b111, 8'h00, 11'h3C0}, 11'h035, pend); resolve(10, 2, 0);
    issue({3'b110, 8'h00, 11'h055}, 11'h047, pend); resolve(0, 1, 1);
    issue({3'b101, 8'h00, 11'h100}, 11'h020, pend); resolve(0, 2, 0);

    // Drive the mispredict counter into saturation.
    for (int k = 0; k < 260; k++) begin
      op = 3'($urandom_range(5, 7));
      issue(mk(op, 11'($urandom)), 11'($urandom), pend);
      resolve(0, 1, 0);
    end

    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 3) == 0) begin
        resolve_valid = 1; flag_z = 1'($urandom); flag_c = 1'($urandom);
        tick();
        resolve_valid = 0;
      end
      op = 3'($urandom_range(0, 7));
      p = ($urandom_range(0, 1) == 0) ? 11'($urandom_range(0, 40)) : 11'($urandom);
      issue(mk(op, 11'($urandom)), p, pend);
      if (pend) resolve($urandom_range(0, 3), 0, 0);
    end

    repeat (4) tick();
    chk("pred_q_empty", pred_q.size(), 0);
    chk("redir_q_empty", redir_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
